// File: rtl/pll_lock_supervisor.sv
// TMDS PLL supervisor: sequences PLL reset, waits for lock with timeout/retry,
// qualifies lock over a stable window and gates the downstream pixel reset.
module pll_lock_supervisor #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int MAX_RETRY      = 3,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_lock,
   input  logic             retry_clr,
   output logic             pll_reset,
   output logic             pll_ready,
   output logic             rst_out_n,
   output logic             fail,
   output logic [1:0]       retry_cnt,
   output logic [CNT_W-1:0] lock_loss_cnt
);

   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int T_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int T_MAX  = (T_A > STABLE_CYCLES) ? T_A : STABLE_CYCLES;
   localparam int TW     = $clog2(T_MAX + 1);

   localparam logic [TW-1:0] RST_LAST    = TW'(PLL_RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);

   localparam logic [2:0] ST_PLL_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_STABLE    = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_LOST      = 3'd4;
   localparam logic [2:0] ST_FAIL      = 3'd5;

   logic [SYNC_N-1:0] sync_q;
   logic              lock_s;
   logic [2:0]        state_q, state_d;
   logic [TW-1:0]     timer_q;
   logic [1:0]        retry_d;
   logic              loss_inc;
   logic              hold_pll_rst;

   assign lock_s = sync_q[SYNC_N-1];

   always_comb begin
      state_d  = state_q;
      retry_d  = retry_cnt;
      loss_inc = 1'b0;
      case (state_q)
         ST_PLL_RST:
            if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
         ST_WAIT_LOCK:
            // lock takes priority over a coincident timeout
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (timer_q == TIMEOUT_LAST) begin
               retry_d = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
               state_d = ((int'(retry_cnt) + 1) >= MAX_RETRY) ? ST_FAIL : ST_PLL_RST;
            end
         ST_STABLE:
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (timer_q == STABLE_LAST) begin
               state_d = ST_RUN;
               retry_d = 2'd0;
            end
         ST_RUN:
            if (!lock_s) begin
               state_d  = ST_LOST;
               loss_inc = 1'b1;
            end
         ST_LOST:
            state_d = ST_PLL_RST;
         ST_FAIL:
            if (retry_clr) begin
               state_d = ST_PLL_RST;
               retry_d = 2'd0;
            end
         default:
            state_d = ST_PLL_RST;
      endcase
   end

   assign hold_pll_rst = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q        <= '0;
         state_q       <= ST_PLL_RST;
         timer_q       <= '0;
         pll_reset     <= 1'b1;
         pll_ready     <= 1'b0;
         rst_out_n     <= 1'b0;
         fail          <= 1'b0;
         retry_cnt     <= 2'd0;
         lock_loss_cnt <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_N-2:0], pll_lock};
         state_q <= state_d;
         if (state_d != state_q)  timer_q <= '0;
         else if (timer_q != '1)  timer_q <= timer_q + 1'b1;
         // PLL reset and fail follow the next state; the downstream reset lags
         // the state by one cycle so it only releases once RUN is established.
         pll_reset <= hold_pll_rst;
         fail      <= (state_d == ST_FAIL);
         pll_ready <= (state_q == ST_RUN);
         rst_out_n <= (state_q == ST_RUN);
         retry_cnt <= retry_d;
         if (loss_inc && (lock_loss_cnt != '1))
            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboarded bench: a phase-level model predicts output change events from a
// lock waveform; a monitor pops and compares on every observed output change.
module tb_pll_lock_supervisor;
   localparam int SYNC = 2;
   localparam int PR   = 16;
   localparam int TO   = 300;
   localparam int SC   = 64;
   localparam int MR   = 3;
   localparam int CW   = 8;
   localparam int MAXN = 30100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_lock = 1'b0;
   logic          retry_clr = 1'b0;
   logic          pll_reset, pll_ready, rst_out_n, fail;
   logic [1:0]    retry_cnt;
   logic [CW-1:0] lock_loss_cnt;

   pll_lock_supervisor #(
      .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(TO),
      .STABLE_CYCLES(SC), .MAX_RETRY(MR), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .retry_clr(retry_clr),
      .pll_reset(pll_reset), .pll_ready(pll_ready), .rst_out_n(rst_out_n),
      .fail(fail), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          prst;
      logic          rdy;
      logic          ron;
      logic          fl;
      logic [1:0]    rc;
      logic [CW-1:0] lc;
   } snap_t;

   typedef struct {
      int    cyc;
      snap_t s;
   } ev_t;

   ev_t   expq[$];
   int    total = 0;
   int    bad = 0;
   bit    lock_arr[MAXN];
   bit    clr_arr[MAXN];
   snap_t exp_s[MAXN];

   function automatic snap_t reset_snap();
      snap_t s;
      s.prst = 1'b1; s.rdy = 1'b0; s.ron = 1'b0; s.fl = 1'b0; s.rc = 2'd0; s.lc = '0;
      return s;
   endfunction

   // lock value the supervisor acts on at edge k (after the synchronizer)
   function automatic bit ls(int k, int n);
      int idx = k - SYNC;
      return (idx >= 0 && idx < n) ? lock_arr[idx] : 1'b0;
   endfunction

   // a phase entered at edge e and left at edge x: next-state outputs cover
   // snapshots [e,x), the ready/downstream reset covers [e+1,x]
   task automatic paint(int e, int x, int n, bit prst, bit fl, bit rdy, int rc, int lc);
      for (int k = (e < 0) ? 0 : e; k < x && k < n; k++) begin
         exp_s[k].prst = prst; exp_s[k].fl = fl;
         exp_s[k].rc = 2'(rc); exp_s[k].lc = CW'(lc);
      end
      for (int k = e + 1; k <= x && k < n; k++) begin
         exp_s[k].rdy = rdy; exp_s[k].ron = rdy;
      end
   endtask

   task automatic model(int n);
      int e = -1, x = 0, ph = 0, rc = 0, lc = 0;
      bit hit;
      snap_t prev;
      ev_t ev;
      while (e < n) begin
         case (ph)
            0: begin x = e + PR; paint(e, x, n, 1, 0, 0, rc, lc); ph = 1; end
            1: begin
               hit = 0; x = e + TO;
               for (int k = e + 1; k <= e + TO; k++)
                  if (!hit && ls(k, n)) begin hit = 1; x = k; end
               paint(e, x, n, 0, 0, 0, rc, lc);
               if (hit) ph = 2;
               else begin rc++; ph = (rc == MR) ? 5 : 0; end
            end
            2: begin
               hit = 0; x = e + SC;
               for (int k = e + 1; k <= e + SC; k++)
                  if (!hit && !ls(k, n)) begin hit = 1; x = k; end
               paint(e, x, n, 0, 0, 0, rc, lc);
               if (hit) ph = 1;
               else begin rc = 0; ph = 3; end
            end
            3: begin
               x = e + 1;
               while (ls(x, n)) x++;
               paint(e, x, n, 0, 0, 1, rc, lc);
               lc = (lc == (1 << CW) - 1) ? lc : lc + 1;
               ph = 4;
            end
            4: begin x = e + 1; paint(e, x, n, 0, 0, 0, rc, lc); ph = 0; end
            default: begin
               x = e + 1;
               while (x < n && !clr_arr[x]) x++;
               paint(e, x, n, 1, 1, 0, rc, lc);
               rc = 0; ph = 0;
            end
         endcase
         e = x;
      end
      prev = reset_snap();
      for (int k = 0; k < n; k++) begin
         if (exp_s[k] != prev) begin ev.cyc = k; ev.s = exp_s[k]; expq.push_back(ev); end
         prev = exp_s[k];
      end
   endtask

   initial begin : monitor
      snap_t prev, cur;
      ev_t ev;
      int cyc;
      cyc = 0;
      prev = reset_snap();
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            cyc = 0; prev = reset_snap();
         end else begin
            cur = {pll_reset, pll_ready, rst_out_n, fail, retry_cnt, lock_loss_cnt};
            if (cur != prev) begin
               total++;
               if (expq.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_change cyc=%0d got=%h want=no change", cyc, cur);
               end else begin
                  ev = expq.pop_front();
                  if (ev.cyc != cyc || ev.s != cur) begin
                     bad++;
                     $display("FAIL event got cyc=%0d rst=%b rdy=%b rstn=%b fail=%b rc=%0d llc=%0d want cyc=%0d rst=%b rdy=%b rstn=%b fail=%b rc=%0d llc=%0d",
                              cyc, cur.prst, cur.rdy, cur.ron, cur.fl, cur.rc, cur.lc,
                              ev.cyc, ev.s.prst, ev.s.rdy, ev.s.ron, ev.s.fl, ev.s.rc, ev.s.lc);
                  end
               end
            end
            prev = cur;
            cyc++;
         end
      end
   end

   task automatic check_reset(string name);
      snap_t cur = {pll_reset, pll_ready, rst_out_n, fail, retry_cnt, lock_loss_cnt};
      total++;
      if (cur != reset_snap()) begin
         bad++;
         $display("FAIL %s_reset got rst=%b rdy=%b rstn=%b fail=%b rc=%0d llc=%0d want 1/0/0/0/0/0",
                  name, cur.prst, cur.rdy, cur.ron, cur.fl, cur.rc, cur.lc);
      end
   endtask

   task automatic set_lock(int a, int b, bit v);
      for (int k = a; k < b; k++) lock_arr[k] = v;
   endtask

   task automatic clr_none(int n);
      for (int k = 0; k < n; k++) clr_arr[k] = 1'b0;
   endtask

   task automatic gen_random(int n);
      int k = 0;
      int len;
      bit v;
      while (k < n) begin
         v   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(20, 400));
         for (int i = 0; i < len && k < n; i++) begin lock_arr[k] = v; k++; end
      end
      for (int i = 0; i < n; i++) clr_arr[i] = ($urandom_range(0, 199) == 0);
   endtask

   // release reset, replay the waveform, then reset asynchronously mid-cycle
   task automatic run_phase(string name, int n);
      model(n);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; pll_lock = lock_arr[0]; retry_clr = clr_arr[0];
      for (int k = 1; k < n; k++) begin
         @(negedge clk);
         pll_lock = lock_arr[k]; retry_clr = clr_arr[k];
      end
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      check_reset(name);
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL %s_pending got=%0d events left want=0", name, expq.size());
         expq.delete();
      end
      pll_lock = 1'b0; retry_clr = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 check_reset("por");
      // lock tied high; stray retry_clr outside FAIL; ends in RUN
      set_lock(0, 120, 1); clr_none(120); clr_arr[50] = 1'b1;
      run_phase("lock_tied", 120);
      // three timeouts into FAIL, then retry_clr restarts and qualifies
      set_lock(0, 990, 0); set_lock(990, 1150, 1); clr_none(1150);
      clr_arr[100] = 1'b1; clr_arr[1000] = 1'b1;
      run_phase("timeout", 1150);
      // five-cycle drop in RUN, then requalification
      set_lock(0, 260, 1); set_lock(150, 155, 0); clr_none(260);
      run_phase("drop", 260);
      // one-cycle glitch restarts STABLE; reset lands in STABLE
      set_lock(0, 40, 0); set_lock(40, 110, 1); lock_arr[70] = 1'b0; clr_none(110);
      run_phase("glitch", 110);
      for (int r = 0; r < 4; r++) begin
         gen_random(3000);
         run_phase("random", 3000);
      end
      // 300 periodic losses saturate the loss counter
      for (int k = 0; k < 30050; k++) lock_arr[k] = ((k % 100) < 95);
      clr_none(30050);
      run_phase("saturate", 30050);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
